// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: merges button and Avalon commands into a run/lap FSM and millisecond timebase.
// Latency: button level -> outputs 2 cycles; Avalon write -> outputs 1 cycle; read data 1 cycle after avalon_read.
// Backpressure: none; every event is accepted in the cycle it occurs, and same-kind events are merged.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   b_run, b_clr               debounced button levels (active high)
//   avalon_write/read/writedata  CPU command/status access; readdata is registered
//   avalon_interrupt           registered lap interrupt (pending & ien)
//   t_ena, t_clr, t_hld        counter tick, counter clear pulse, display freeze
//   s_run, s_hld               status: counting active, hold active
module stopwatch_ctrl #(
  parameter int MSPN = 24000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        b_run,
  input  logic        b_clr,
  input  logic        avalon_write,
  input  logic        avalon_read,
  input  logic [31:0] avalon_writedata,
  output logic [31:0] avalon_readdata,
  output logic        avalon_interrupt,
  output logic        t_ena,
  output logic        t_clr,
  output logic        t_hld,
  output logic        s_run,
  output logic        s_hld
);

  localparam int PW = (MSPN > 1) ? $clog2(MSPN) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(MSPN - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HSTOP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic            r_run_q, r_run_prev, r_clr_q, r_clr_prev;
  logic            w_run_ev, w_clr_ev;
  logic            w_clr_pulse, w_lap;
  logic            w_s_run, w_hld;
  logic [PW-1:0]   r_presc;
  logic            r_t_ena, r_t_clr;
  logic            r_ien, r_pend, r_irq;
  logic [31:0]     r_rdata;
  logic [31:0]     w_status;
  logic            w_unused;

  // Buttons are sampled, then compared with the previous sample. Both flops
  // reset to 1 so a button held through reset release is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_q    <= 1'b1;
      r_run_prev <= 1'b1;
      r_clr_q    <= 1'b1;
      r_clr_prev <= 1'b1;
    end else begin
      r_run_q    <= b_run;
      r_run_prev <= r_run_q;
      r_clr_q    <= b_clr;
      r_clr_prev <= r_clr_q;
    end
  end

  // Same-kind events from both requesters collapse into one event.
  assign w_run_ev = (r_run_q & ~r_run_prev) | (avalon_write & avalon_writedata[0]);
  assign w_clr_ev = (r_clr_q & ~r_clr_prev) | (avalon_write & avalon_writedata[1]);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_STOP;
    else        r_state <= w_nxt;
  end

  // FSM: next state; run_ev always has priority over clr_ev except in STOP,
  // where both together mean "clear and start".
  always_comb begin
    w_nxt       = r_state;
    w_clr_pulse = 1'b0;
    w_lap       = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (w_clr_ev) w_clr_pulse = 1'b1;
        if (w_run_ev) w_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_run_ev) begin
          w_nxt = ST_STOP;
        end else if (w_clr_ev) begin
          w_nxt = ST_HOLD;
          w_lap = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_run_ev)      w_nxt = ST_HSTOP;
        else if (w_clr_ev) w_nxt = ST_RUN;
      end
      ST_HSTOP: begin
        if (w_run_ev)      w_nxt = ST_HOLD;
        else if (w_clr_ev) w_nxt = ST_STOP;
      end
      default: w_nxt = ST_STOP;
    endcase
  end

  // FSM: decoded outputs
  always_comb begin
    w_s_run = 1'b0;
    w_hld   = 1'b0;
    case (r_state)
      ST_RUN:   w_s_run = 1'b1;
      ST_HOLD: begin
        w_s_run = 1'b1;
        w_hld   = 1'b1;
      end
      ST_HSTOP: w_hld = 1'b1;
      default: begin
        w_s_run = 1'b0;
        w_hld   = 1'b0;
      end
    endcase
  end

  // Prescaler keeps its phase while stopped so restarting continues the
  // partial millisecond; only a clear resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_t_ena <= 1'b0;
      r_t_clr <= 1'b0;
    end else begin
      r_t_clr <= w_clr_pulse;
      r_t_ena <= w_s_run && (r_presc == P_LAST);
      if (w_clr_pulse)
        r_presc <= '0;
      else if (w_s_run)
        r_presc <= (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
    end
  end

  // Interrupt: a lap in the same cycle as an acknowledge keeps pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ien  <= 1'b0;
      r_pend <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (avalon_write) r_ien <= avalon_writedata[8];
      if (w_lap)
        r_pend <= 1'b1;
      else if (avalon_write && avalon_writedata[9])
        r_pend <= 1'b0;
      r_irq <= r_pend & r_ien;
    end
  end

  assign w_status = {22'd0, r_pend, r_ien, 4'd0, w_hld, w_s_run, r_state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_rdata <= '0;
    else if (avalon_read) r_rdata <= w_status;
  end

  assign w_unused = ^{avalon_writedata[31:10], avalon_writedata[7:2]};

  assign avalon_readdata  = r_rdata;
  assign avalon_interrupt = r_irq;
  assign t_ena            = r_t_ena;
  assign t_clr            = r_t_clr;
  assign t_hld            = w_hld;
  assign s_hld            = w_hld;
  assign s_run            = w_s_run;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios followed by random buttons and CPU traffic.
// The reference model tracks "running" and "holding" flags plus a millisecond phase;
// each cycle's expected outputs go into a queue that a negedge monitor pops and compares.
module tb_stopwatch_ctrl;
  localparam int MSPN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        b_run = 1'b1;
  logic        b_clr = 1'b0;
  logic        avalon_write = 1'b0;
  logic        avalon_read = 1'b0;
  logic [31:0] avalon_writedata = 32'd0;
  logic [31:0] avalon_readdata;
  logic        avalon_interrupt, t_ena, t_clr, t_hld, s_run, s_hld;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MSPN(MSPN)) dut (
    .clk(clk), .rst_n(rst_n), .b_run(b_run), .b_clr(b_clr),
    .avalon_write(avalon_write), .avalon_read(avalon_read),
    .avalon_writedata(avalon_writedata), .avalon_readdata(avalon_readdata),
    .avalon_interrupt(avalon_interrupt), .t_ena(t_ena), .t_clr(t_clr),
    .t_hld(t_hld), .s_run(s_run), .s_hld(s_hld)
  );

  int total = 0;
  int bad = 0;
  logic [37:0] exp_q[$];

  // reference model state
  bit          m_rq, m_rp, m_cq, m_cp;
  bit          m_running, m_holding, m_ien, m_pend;
  bit          m_tena, m_tclr, m_irq;
  int          m_phase;
  logic [31:0] m_rdata;
  bit          cur_br, cur_bc;

  task automatic model_reset();
    m_rq = 1; m_rp = 1; m_cq = 1; m_cp = 1;
    m_running = 0; m_holding = 0; m_ien = 0; m_pend = 0;
    m_tena = 0; m_tclr = 0; m_irq = 0; m_phase = 0; m_rdata = 32'd0;
  endtask

  // One clock edge of the reference model, using the inputs held during the cycle.
  task automatic model_edge(input bit br, input bit bc, input bit wr,
                            input logic [31:0] wd, input bit rd);
    bit run_ev, clr_ev, clear, lap;
    logic [31:0] st;
    run_ev = (m_rq && !m_rp) || (wr && wd[0]);
    clr_ev = (m_cq && !m_cp) || (wr && wd[1]);
    st = 32'd0;
    st[1] = m_holding;
    st[0] = m_running ^ m_holding;
    st[2] = m_running;
    st[3] = m_holding;
    st[8] = m_ien;
    st[9] = m_pend;
    if (rd) m_rdata = st;
    m_irq  = m_pend && m_ien;
    m_tena = m_running && (m_phase == MSPN - 1);
    clear  = clr_ev && !m_running && !m_holding;
    lap    = clr_ev && !run_ev && m_running && !m_holding;
    if (clear) m_phase = 0;
    else if (m_running) m_phase = (m_phase + 1) % MSPN;
    m_tclr = clear;
    if (lap) m_pend = 1;
    else if (wr && wd[9]) m_pend = 0;
    if (wr) m_ien = wd[8];
    if (run_ev) m_running = !m_running;
    else if (clr_ev && !clear) m_holding = !m_holding;
    m_rp = m_rq; m_rq = br;
    m_cp = m_cq; m_cq = bc;
  endtask

  task automatic step(input bit br, input bit bc, input bit wr,
                      input logic [31:0] wd, input bit rd);
    b_run = br; b_clr = bc;
    avalon_write = wr; avalon_writedata = wd; avalon_read = rd;
    cur_br = br; cur_bc = bc;
    @(posedge clk);
    model_edge(br, bc, wr, wd, rd);
    exp_q.push_back({m_tena, m_tclr, m_holding, m_running, m_holding, m_irq, m_rdata});
    #1;
  endtask

  task automatic hold_btn(input bit br, input bit bc, input int n);
    for (int i = 0; i < n; i++) step(br, bc, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic cpu_wr(input logic [31:0] wd);
    step(cur_br, cur_bc, 1'b1, wd, 1'b0);
  endtask

  task automatic cpu_rd();
    step(cur_br, cur_bc, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic check_zero(input string name);
    logic [37:0] a;
    a = {t_ena, t_clr, t_hld, s_run, s_hld, avalon_interrupt, avalon_readdata};
    total++;
    if (a !== 38'd0) begin
      bad++;
      $display("FAIL %s: outputs got %h expected 0", name, a);
    end
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic mid_reset(input string name);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero(name);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // monitor: pops one expected record per cycle
  initial begin
    logic [37:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {t_ena, t_clr, t_hld, s_run, s_hld, avalon_interrupt, avalon_readdata};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs @%0t: got ena/clr/hld/run/shld/irq/rd=%h expected %h",
                   $time, a, e);
        end
      end
    end
  end

  initial begin
    #300000;
    bad++;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cur_br = 1; cur_bc = 0;
    #1 check_zero("reset_state");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // run button held through reset release: no event
    hold_btn(1, 0, 3);
    // release and re-press: counting, t_ena every MSPN cycles
    hold_btn(0, 0, 2);
    hold_btn(1, 0, 13);
    // lap with interrupt enabled, then acknowledge, then release hold
    cpu_wr(32'h100);
    hold_btn(1, 1, 5);
    cpu_wr(32'h200);
    hold_btn(1, 0, 3);
    hold_btn(1, 1, 4);
    hold_btn(0, 0, 3);
    // stop
    hold_btn(1, 0, 4);
    // button run and CPU run in the same detection cycle while stopped
    hold_btn(0, 0, 2);
    step(1, 0, 1'b0, 32'd0, 1'b0);
    step(1, 0, 1'b1, 32'h1, 1'b0);
    hold_btn(1, 0, 4);
    // both buttons in RUN: stop, no clear
    hold_btn(0, 0, 2);
    hold_btn(1, 1, 4);
    // both buttons in STOP: clear pulse and start from phase 0
    hold_btn(0, 0, 2);
    hold_btn(1, 1, 7);
    // HOLD -> HSTOP -> STOP, acknowledge, read status
    hold_btn(0, 0, 2);
    hold_btn(0, 1, 3);
    hold_btn(1, 1, 3);
    hold_btn(1, 0, 2);
    hold_btn(1, 1, 3);
    cpu_wr(32'h200);
    cpu_rd();
    hold_btn(0, 0, 2);
    // lap and acknowledge in the same cycle: pending survives
    cpu_wr(32'h100);
    hold_btn(1, 0, 3);
    hold_btn(0, 0, 1);
    step(0, 1, 1'b0, 32'd0, 1'b0);
    step(0, 1, 1'b1, 32'h300, 1'b0);
    hold_btn(0, 1, 3);
    cpu_rd();
    hold_btn(0, 1, 1);
    // reset while holding
    mid_reset("reset_mid_hold");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit br, bc, wr, rd;
      logic [31:0] wd;
      br = cur_br; bc = cur_bc;
      if ($urandom_range(0, 5) == 0) br = !br;
      if ($urandom_range(0, 5) == 0) bc = !bc;
      wr = ($urandom_range(0, 7) == 0);
      wd = wr ? ($urandom() & 32'h0000_0303) : 32'd0;
      rd = ($urandom_range(0, 3) == 0);
      step(br, bc, wr, wd, rd);
      if (i == 1500) mid_reset("reset_mid_random");
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
